multichannel_gain_stage: RTL and testbench
==========================================

MULTICHANNEL_GAIN_STAGE -- requirements
Module: multichannel_gain_stage

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of audio channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-003 SHALL have parameter GAIN_W, default 8, unsigned gain width; unity gain = 2^(GAIN_W-1).
REQ-004 SHALL have parameter RAMP_STEP, default 4, maximum gain change per output frame (1..2^GAIN_W).
REQ-005 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in_data  in  NUM_CH*DATA_W  packed signed samples, channel k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port in_valid  in  NUM_CH  per-channel one-cycle sample strobe.
REQ-009 SHALL have port volume  in  GAIN_W  target gain.
REQ-010 SHALL have port mute  in  1  forces target gain to 0.
REQ-011 SHALL have port out_data  out  NUM_CH*DATA_W  packed scaled samples, same lane order as in_data.
REQ-012 SHALL have port out_valid  out  1  frame available.
REQ-013 SHALL have port out_ready  in  1  downstream accepts frame.
REQ-014 SHALL have port overrun  out  1  one-cycle pulse, sample dropped.
REQ-015 SHALL have port gain_cur  out  GAIN_W  gain currently applied.

Function
REQ-016 SHALL hold one capture register and one captured bit per channel; an in_valid on a channel whose bit is clear stores the sample and sets the bit.
REQ-017 SHALL drop an in_valid on a channel whose bit is already set, keep the stored sample, and pulse overrun on the next edge; multiple channels overrunning in one cycle produce one pulse.
REQ-018 SHALL use states COLLECT, MULT, OUT.
REQ-019 COLLECT -> MULT on the edge where the captured mask becomes all ones, including when all channels arrive in the same cycle or the mask was already full on entry.
REQ-020 On the MULT edge: out_data gets the scaled capture registers, out_valid is set, the mask clears, state -> OUT; latency is 2 edges from the capture of the last sample to out_valid high.
REQ-021 Captures SHALL continue during MULT and OUT into the cleared mask for the next frame.
REQ-022 In OUT, out_data and out_valid SHALL hold stable until out_valid && out_ready; on that edge out_valid clears and state -> COLLECT.
REQ-023 Scaling SHALL be sample (signed DATA_W) times gain_cur (zero-extended to GAIN_W+1 signed), arithmetic-shifted right by GAIN_W-1, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-024 Target gain SHALL be 0 when mute=1, otherwise volume, sampled on the MULT edge.
REQ-025 On each MULT edge, after use, gain_cur SHALL move toward the target by min(RAMP_STEP, |target - gain_cur|); it is unchanged when equal.
REQ-026 All channels of one frame SHALL use the same gain_cur value.

Reset
REQ-027 While reset=1 on an edge: state = COLLECT, mask cleared, capture registers 0, out_data 0, out_valid 0, overrun 0, gain_cur 0 (fade-in after reset).
REQ-028 Reset mid-frame or in OUT SHALL discard any pending or presented frame; in_valid during reset is ignored.

Verification
REQ-029 RAMP_STEP=256, volume=128: L=1000, R=-1000 both valid in cycle 0 -> first frame out is 0,0 (gain_cur 0 at the MULT edge); next frame out is 1000,-1000 with out_valid 2 edges after capture.
REQ-030 RAMP_STEP=256, gain at 255: L=32767 -> 32767 (saturated); R=-32768 -> -32768 (saturated); L=100 -> 199.
REQ-031 Settled at unity: L valid cycle 0 (=5), L again cycle 3 (=9), R valid cycle 5 -> overrun pulse after cycle 3; out L=5; out_valid 2 edges after cycle 5.
REQ-032 out_ready low 10 cycles with out_valid high -> out_data stable; next frame captured meanwhile; after handshake out_valid low exactly 1 cycle then high with the new frame.
REQ-033 gain_cur=128, RAMP_STEP=4, mute=1 -> successive frames use 128,124,...,4,0; 0 is reached on the 33rd frame and held; mute=0 with volume=128 ramps back up symmetrically.
REQ-034 Assert reset while in OUT with the next frame half-captured -> out_valid 0 and gain_cur 0 next edge; no stale frame emitted afterwards.

Source files
------------

// File: rtl/multichannel_gain_stage.sv
// Multichannel gain stage: gathers one sample per channel into a frame, scales the
// frame by a ramped gain with saturation, and presents it on a valid/ready output.
module multichannel_gain_stage #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [GAIN_W-1:0]          volume,
  input  logic                       mute,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic [GAIN_W-1:0]          gain_cur
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [GAIN_W:0] STEP = (GAIN_W + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {COLLECT, MULT, OUT} state_t;

  state_t state_reg, state_next;
  logic [NUM_CH-1:0] mask_reg, mask_base, mask_next, accept, drop;
  logic mask_full;
  logic load_out, release_out;
  logic signed [DATA_W-1:0] cap_reg [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] scaled;
  logic [GAIN_W-1:0] target, gain_next;
  logic [GAIN_W:0] gain_ext, target_ext;

  function automatic logic [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] s,
                                               input logic [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] s_ext, g_ext, prod, shifted;
    s_ext   = PROD_W'(s);
    g_ext   = PROD_W'($signed({1'b0, g}));
    prod    = s_ext * g_ext;
    shifted = prod >>> (GAIN_W - 1);
    if (shifted > SAT_MAX)      shifted = SAT_MAX;
    else if (shifted < SAT_MIN) shifted = SAT_MIN;
    return DATA_W'(shifted);
  endfunction

  // In MULT the frame is being consumed, so new samples land in an already-cleared mask.
  assign mask_base = (state_reg == MULT) ? '0 : mask_reg;
  assign accept    = in_valid & ~mask_base;
  assign drop      = in_valid & mask_base;
  assign mask_next = mask_base | accept;
  assign mask_full = &mask_next;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= COLLECT;
    else       state_reg <= state_next;
  end

  // A frame completed while presenting skips COLLECT, leaving a one-cycle bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (mask_full) state_next = MULT;
      MULT:    state_next = OUT;
      OUT:     if (out_ready) state_next = mask_full ? MULT : COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    load_out    = (state_reg == MULT);
    release_out = (state_reg == OUT) && out_ready;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset)           cap_reg[gi] <= '0;
        else if (accept[gi]) cap_reg[gi] <= in_data[gi*DATA_W +: DATA_W];
      end
      assign scaled[gi*DATA_W +: DATA_W] = scale(cap_reg[gi], gain_cur);
    end
  endgenerate

  assign target = mute ? '0 : volume;

  always_comb begin
    gain_ext   = {1'b0, gain_cur};
    target_ext = {1'b0, target};
    gain_next  = gain_cur;
    if (target_ext > gain_ext) begin
      if (target_ext - gain_ext > STEP) gain_next = GAIN_W'(gain_ext + STEP);
      else                              gain_next = target;
    end else if (target_ext < gain_ext) begin
      if (gain_ext - target_ext > STEP) gain_next = GAIN_W'(gain_ext - STEP);
      else                              gain_next = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg  <= '0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      gain_cur  <= '0;
    end else begin
      mask_reg <= mask_next;
      overrun  <= |drop;
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= scaled;
        gain_cur  <= gain_next;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multichannel_gain_stage.sv
// Scoreboard bench for multichannel_gain_stage: a bench-side gain/scale model
// queues expected frames as samples are driven; a monitor pops them on handshake.
module tb_multichannel_gain_stage;
  localparam int NUM_CH = 2, DATA_W = 16, GAIN_W = 8, RAMP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0] in_valid = '0;
  logic [GAIN_W-1:0] volume = 8'd128;
  logic mute = 1'b0;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic overrun;
  logic [GAIN_W-1:0] gain_cur;

  multichannel_gain_stage #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAIN_W(GAIN_W), .RAMP_STEP(RAMP)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .volume(volume),
    .mute(mute), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .gain_cur(gain_cur)
  );

  always #5 clk = ~clk;

  typedef struct { int l; int r; int g; } frame_t;
  frame_t sb[$];
  int n_checks = 0, n_pass = 0;
  int g_model = 0;
  int m_cap [2];
  logic [1:0] m_mask = 2'b00;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_scale(input int s, input int g);
    longint p, q, div;
    div = longint'(1) << (GAIN_W - 1);
    p = longint'(s) * longint'(g);
    if (p >= 0) q = p / div;
    else        q = -((-p + div - 1) / div);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of samples; model capture, overrun and frame completion.
  task automatic send(input logic [1:0] vm, input int l, input int r);
    bit exp_ovr;
    int tgt;
    frame_t f;
    exp_ovr = 1'b0;
    in_data = {r[15:0], l[15:0]};
    in_valid = vm;
    for (int ch = 0; ch < 2; ch++) begin
      if (vm[ch]) begin
        if (m_mask[ch]) exp_ovr = 1'b1;
        else begin
          m_mask[ch] = 1'b1;
          m_cap[ch] = (ch == 0) ? l : r;
        end
      end
    end
    tick();
    in_valid = '0;
    check("overrun", overrun, exp_ovr);
    if (m_mask == 2'b11) begin
      f.l = exp_scale(m_cap[0], g_model);
      f.r = exp_scale(m_cap[1], g_model);
      tgt = mute ? 0 : int'(volume);
      if (tgt > g_model)      g_model = (tgt - g_model > RAMP) ? g_model + RAMP : tgt;
      else if (tgt < g_model) g_model = (g_model - tgt > RAMP) ? g_model - RAMP : tgt;
      f.g = g_model;
      sb.push_back(f);
      m_mask = 2'b00;
    end
  endtask

  task automatic frame(input int l, input int r);
    send(2'b11, l, r);
    tick();
    tick();
  endtask

  task automatic rand_frame();
    logic signed [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    frame(int'(a), int'(b));
  endtask

  task automatic ramp_to(input int vol, input bit m);
    volume = 8'(vol);
    mute = m;
    for (int i = 0; i < 80; i++) begin
      if (g_model == (m ? 0 : vol)) break;
      rand_frame();
    end
  endtask

  always @(negedge clk) begin : monitor
    frame_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_frame", 1, 0);
      else begin
        e = sb.pop_front();
        $display("frame L=%0d R=%0d gain_after=%0d", $signed(out_data[15:0]),
                 $signed(out_data[31:16]), gain_cur);
        check("out_L", longint'($signed(out_data[15:0])), e.l);
        check("out_R", longint'($signed(out_data[31:16])), e.r);
        check("gain_cur", gain_cur, e.g);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset with in_valid active: must be ignored.
    in_valid = 2'b11;
    in_data = {16'd77, 16'd55};
    tick();
    tick();
    in_valid = '0;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_gain", gain_cur, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_frame_from_reset", out_valid, 0);
    end

    // First frame after reset uses gain 0; out_valid two edges after capture.
    volume = 8'd128;
    send(2'b11, 1000, -1000);
    check("lat_edge1", out_valid, 0);
    tick();
    check("lat_edge2", out_valid, 1);
    tick();

    ramp_to(128, 1'b0);
    frame(1000, -1000);
    ramp_to(255, 1'b0);
    frame(32767, -32768);
    frame(100, -100);
    frame(-32768, 32767);
    ramp_to(128, 1'b0);

    // Overrun on a channel that already holds a sample; original sample kept.
    send(2'b01, 5, 0);
    tick();
    tick();
    send(2'b01, 9, 0);
    tick();
    check("overrun_one_cycle", overrun, 0);
    send(2'b10, 0, -7);
    check("ovr_lat_edge1", out_valid, 0);
    tick();
    check("ovr_lat_edge2", out_valid, 1);
    tick();
    tick();

    // Backpressure: hold frame A for 10 cycles while frame B is captured.
    out_ready = 1'b0;
    send(2'b11, 1234, -4321);
    tick();
    check("stall_valid", out_valid, 1);
    send(2'b11, 42, -42);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid_hold", out_valid, 1);
      check("stall_L", longint'($signed(out_data[15:0])), sb[0].l);
      check("stall_R", longint'($signed(out_data[31:16])), sb[0].r);
    end
    out_ready = 1'b1;
    tick();
    check("bubble_low", out_valid, 0);
    tick();
    check("bubble_high", out_valid, 1);
    tick();
    tick();

    // Mute fade-out to 0, hold, then fade back in.
    ramp_to(0, 1'b1);
    rand_frame();
    rand_frame();
    ramp_to(128, 1'b0);

    // Reset while presenting with the next frame half captured.
    out_ready = 1'b0;
    send(2'b11, 300, -300);
    tick();
    check("pre_rst_valid", out_valid, 1);
    send(2'b01, 111, 0);
    reset = 1'b1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_gain", gain_cur, 0);
    reset = 1'b0;
    sb.delete();
    g_model = 0;
    m_mask = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_frame", out_valid, 0);
    end
    send(2'b10, 0, 222);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("half_frame_discarded", out_valid, 0);
    end
    send(2'b01, 333, 0);
    tick();
    check("post_rst_frame", out_valid, 1);
    tick();
    tick();

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
